adsb_spi_rx: RTL and testbench

- Downstream consumer of the ADS-B-to-SPI bridge's serial output (spi_sck, spi_mosi, spi_ss).
- Oversamples the SPI link in the clk8M domain as an SPI mode-0 slave and deserialises bytes MSB-first.
- Tags each frame's final byte and any truncated frame.
- Buffers bytes in a FIFO behind a valid/ready stream for the message decoder / host interface.

---
 rtl/adsb_pkg.sv | 19 +
 rtl/adsb_spi_rx_if.sv | 29 ++
 rtl/sync_fifo.sv | 59 +++++
 rtl/adsb_spi_rx.sv | 168 ++++++++++++++++
 tb/tb_adsb_spi_rx.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/adsb_pkg.sv
// Shared ADS-B SPI definitions: byte width, FIFO word layout and the
// standard ADS-B message lengths used by downstream consumers.
`timescale 1ns/1ps
package adsb_pkg;

  localparam int SPI_BYTE_W       = 8;
  localparam int ADSB_LONG_BYTES  = 14;
  localparam int ADSB_SHORT_BYTES = 7;

  // One received byte plus its frame-boundary tags.
  typedef struct packed {
    logic                  err;
    logic                  last;
    logic [SPI_BYTE_W-1:0] data;
  } fifo_word_t;

  localparam int FIFO_WORD_W = $bits(fifo_word_t);

endpackage

// File: rtl/adsb_spi_rx_if.sv
// Byte stream from the SPI receiver to the message decoder / host side.
// The master presents data/last/err/valid and the slave answers with ready.
`timescale 1ns/1ps
interface adsb_spi_rx_if;
  import adsb_pkg::*;

  logic [SPI_BYTE_W-1:0] out_data;
  logic                  out_last;
  logic                  out_err;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output out_data,
    output out_last,
    output out_err,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_last,
    input  out_err,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO. The head word is visible on
// pop_data_o whenever empty_o is low. A pop in the same cycle as a push to
// a full FIFO frees the slot first, so that push is still accepted.
`timescale 1ns/1ps
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 10
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             pop_ok;
  logic             push_ok;

  assign empty_o    = (wr_ptr_q == rd_ptr_q);
  assign full_o     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_ok     = pop_i && !empty_o;
  assign push_ok    = push_i && (!full_o || pop_ok);
  assign pop_data_o = mem_q[rd_ptr_q[AW-1:0]];

  // Advance pointers on accepted pushes and pops.
  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_ok};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_ok};
  end

  // Pointer state; storage itself needs no reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Write storage on every accepted push.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end
  end

endmodule

// File: rtl/adsb_spi_rx.sv
// SPI mode-0 slave receiver for the ADS-B bridge output. Oversamples
// sck/mosi/ss in the clk8M domain, deserialises bytes MSB-first, holds the
// newest byte back one step so the final byte of a frame can be tagged
// last (and err if the frame ended mid-byte), and queues words in a FWFT
// FIFO behind a valid/ready stream. Counts FIFO-full drops and empty frames.
`timescale 1ns/1ps
module adsb_spi_rx
  import adsb_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 8
) (
  input  logic              clk8M,
  input  logic              rst,
  input  logic              spi_sck,
  input  logic              spi_mosi,
  input  logic              spi_ss,
  adsb_spi_rx_if.master     rx,
  output logic [CNT_W-1:0]  ovf_cnt,
  output logic [CNT_W-1:0]  empty_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // Synchroniser chains: [1] is the synced value, [2] the previous one.
  logic [2:0] sck_q;
  logic [2:0] ss_q;
  logic [1:0] mosi_q;
  // Marks when the ss chain holds real pin samples rather than reset presets.
  logic [1:0] sync_vld_q;

  logic sck_rise, ss_rise, ss_fall, ss_lo, mosi_s;

  // Frame state.
  logic                  armed_q, armed_d;
  logic                  frame_q, frame_d;
  logic [SPI_BYTE_W-1:0] shift_q, shift_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [SPI_BYTE_W-1:0] pend_q, pend_d;
  logic                  pend_vld_q, pend_vld_d;
  logic [CNT_W-1:0]      empty_cnt_q, empty_cnt_d;
  logic [CNT_W-1:0]      ovf_cnt_q, ovf_cnt_d;

  // FIFO side.
  logic       push;
  fifo_word_t push_word;
  fifo_word_t head;
  logic       fifo_full, fifo_empty;
  logic       pop, drop;

  assign sck_rise = sck_q[1] & ~sck_q[2];
  assign ss_rise  = ss_q[1] & ~ss_q[2];
  assign ss_fall  = ~ss_q[1] & ss_q[2];
  assign ss_lo    = ~ss_q[1];
  assign mosi_s   = mosi_q[1];

  // Two-stage synchronisers plus an edge-detect stage; idle is sck=0, ss=1.
  always_ff @(posedge clk8M or negedge rst) begin
    if (!rst) begin
      sck_q      <= 3'b000;
      ss_q       <= 3'b111;
      mosi_q     <= 2'b00;
      sync_vld_q <= 2'b00;
    end else begin
      sck_q      <= {sck_q[1:0], spi_sck};
      ss_q       <= {ss_q[1:0], spi_ss};
      mosi_q     <= {mosi_q[0], spi_mosi};
      sync_vld_q <= {sync_vld_q[0], 1'b1};
    end
  end

  // Frame deserialiser: a frame only opens on a genuine ss fall seen after
  // ss was observed high, so a reset in mid-frame discards the rest of it.
  always_comb begin
    armed_d     = armed_q | (sync_vld_q[1] & ss_q[1]);
    frame_d     = frame_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    pend_d      = pend_q;
    pend_vld_d  = pend_vld_q;
    empty_cnt_d = empty_cnt_q;
    push        = 1'b0;
    push_word   = '0;
    if (ss_fall && armed_q) begin
      frame_d   = 1'b1;
      bit_cnt_d = '0;
      shift_d   = '0;
    end else if (ss_rise && frame_q) begin
      frame_d    = 1'b0;
      bit_cnt_d  = '0;
      pend_vld_d = 1'b0;
      if (pend_vld_q) begin
        push           = 1'b1;
        push_word.data = pend_q;
        push_word.last = 1'b1;
        push_word.err  = (bit_cnt_q != 3'd0);
      end else begin
        empty_cnt_d = sat_inc(empty_cnt_q);
      end
    end else if (sck_rise && ss_lo && frame_q) begin
      shift_d   = {shift_q[SPI_BYTE_W-2:0], mosi_s};
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        // Older pending byte is known not to be final: release it.
        push           = pend_vld_q;
        push_word.data = pend_q;
        pend_d         = shift_d;
        pend_vld_d     = 1'b1;
      end
    end
  end

  assign pop  = rx.out_valid && rx.out_ready;
  assign drop = push && fifo_full && !pop;

  // Saturating count of bytes lost to a full FIFO.
  always_comb begin
    ovf_cnt_d = drop ? sat_inc(ovf_cnt_q) : ovf_cnt_q;
  end

  // Frame and counter state registers.
  always_ff @(posedge clk8M or negedge rst) begin
    if (!rst) begin
      armed_q     <= 1'b0;
      frame_q     <= 1'b0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      pend_q      <= '0;
      pend_vld_q  <= 1'b0;
      empty_cnt_q <= '0;
      ovf_cnt_q   <= '0;
    end else begin
      armed_q     <= armed_d;
      frame_q     <= frame_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      pend_q      <= pend_d;
      pend_vld_q  <= pend_vld_d;
      empty_cnt_q <= empty_cnt_d;
      ovf_cnt_q   <= ovf_cnt_d;
    end
  end

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FIFO_WORD_W)
  ) u_fifo (
    .clk_i       (clk8M),
    .rst_ni      (rst),
    .push_i      (push),
    .push_data_i (push_word),
    .pop_i       (pop),
    .pop_data_o  (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // Stream outputs are forced to zero while nothing is queued.
  assign rx.out_valid = ~fifo_empty;
  assign rx.out_data  = fifo_empty ? '0 : head.data;
  assign rx.out_last  = ~fifo_empty & head.last;
  assign rx.out_err   = ~fifo_empty & head.err;
  assign ovf_cnt      = ovf_cnt_q;
  assign empty_cnt    = empty_cnt_q;

endmodule

// File: tb/tb_adsb_spi_rx.sv
// Scoreboard bench for adsb_spi_rx: frames are described as byte lists plus
// trailing partial bits; a frame-level model turns them into expected words.
`timescale 1ns/1ps
module tb_adsb_spi_rx;
  import adsb_pkg::*;

  localparam int DEPTH = 16;
  localparam int CW    = 8;
  localparam int THALF = 500;   // 1 MHz sck

  logic          clk8M = 1'b0;
  logic          rst = 1'b0;
  logic          spi_sck = 1'b0;
  logic          spi_mosi = 1'b0;
  logic          spi_ss = 1'b1;
  logic [CW-1:0] ovf_cnt, empty_cnt;

  adsb_spi_rx_if rx ();

  adsb_spi_rx #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk8M     (clk8M),
    .rst       (rst),
    .spi_sck   (spi_sck),
    .spi_mosi  (spi_mosi),
    .spi_ss    (spi_ss),
    .rx        (rx),
    .ovf_cnt   (ovf_cnt),
    .empty_cnt (empty_cnt)
  );

  always #62.5 clk8M = ~clk8M;

  int         checks = 0;
  int         failures = 0;
  logic [9:0] sb[$];
  int         ovf_exp = 0;
  int         empty_exp = 0;
  int         ready_mode = 0;  // 0 always, 1 never, 2 pattern 1,0,0,1, 3 random
  int         cyc = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h required=%0h", name, got, exp);
    end
  endtask

  // Frame-level reference: n complete bytes become n words, the final one
  // tagged last (and err when trailing bits exist). Only the first 'free'
  // words fit; the rest are counted as overflow. No bytes means an empty frame.
  task automatic model_frame(input logic [7:0] q[$], input int partial, input int free);
    int n = q.size();
    if (n == 0) begin
      if (empty_exp < 255) empty_exp++;
    end
    for (int i = 0; i < n; i++) begin
      logic lst = (i == n - 1);
      logic er  = lst && (partial > 0);
      if (i < free) sb.push_back({er, lst, q[i]});
      else if (ovf_exp < 255) ovf_exp++;
    end
  endtask

  // out_valid must be up within four clk8M cycles of the triggering edge.
  task automatic watch_valid(input string name);
    fork
      begin
        bit seen = 1'b0;
        for (int k = 0; k < 4 && !seen; k++) begin
          @(posedge clk8M);
          #1;
          if (rx.out_valid) seen = 1'b1;
        end
        check(name, {31'd0, seen}, 32'd1);
      end
    join_none
  endtask

  task automatic send_bit(input logic b);
    spi_mosi = b;
    #THALF;
    spi_sck = 1'b1;
    #THALF;
    spi_sck = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] q[$], input int partial, input bit watch);
    int nb = q.size() * 8 + partial;
    spi_ss = 1'b0;
    for (int idx = 0; idx < nb; idx++) begin
      logic [7:0] cur;
      logic       b;
      if (idx < q.size() * 8) begin
        cur = q[idx / 8];
        b   = cur[7 - (idx % 8)];
      end else begin
        b = 1'($urandom_range(0, 1));
      end
      spi_mosi = b;
      #THALF;
      spi_sck = 1'b1;
      if (watch && idx == 15) watch_valid("latency_byte16");
      #THALF;
      spi_sck = 1'b0;
    end
    #THALF;
    spi_ss = 1'b1;
    if (watch) watch_valid("latency_final");
    #(2 * THALF);
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 3000 && sb.size() != 0; k++) @(posedge clk8M);
    repeat (4) @(posedge clk8M);
    check(name, sb.size(), 0);
  endtask

  // Consumer ready generator.
  initial begin
    rx.out_ready = 1'b0;
    forever begin
      @(posedge clk8M);
      #2;
      cyc++;
      case (ready_mode)
        0: rx.out_ready = 1'b1;
        1: rx.out_ready = 1'b0;
        2: rx.out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: rx.out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pops the scoreboard on each handshake and checks stall hold.
  logic       prev_stall = 1'b0;
  logic [9:0] prev_w = '0;
  always @(negedge clk8M) begin
    logic [9:0] w;
    w = {rx.out_err, rx.out_last, rx.out_data};
    if (!rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid_held", {31'd0, rx.out_valid}, 32'd1);
        check("stall_word_held", {22'd0, w}, {22'd0, prev_w});
      end
      if (rx.out_valid && rx.out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word got=%0h required=none", w);
        end else begin
          logic [9:0] e;
          e = sb.pop_front();
          check("word", {22'd0, w}, {22'd0, e});
        end
      end
      prev_stall = rx.out_valid && !rx.out_ready;
      prev_w     = w;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q[$];

    // Reset state.
    repeat (3) @(posedge clk8M);
    #1;
    check("rst_valid", {31'd0, rx.out_valid}, 0);
    check("rst_data", {24'd0, rx.out_data}, 0);
    check("rst_last", {31'd0, rx.out_last}, 0);
    check("rst_err", {31'd0, rx.out_err}, 0);
    check("rst_ovf", {24'd0, ovf_cnt}, 0);
    check("rst_empty", {24'd0, empty_cnt}, 0);
    rst = 1'b1;
    ready_mode = 0;
    repeat (4) @(posedge clk8M);

    // Reset in mid-frame after 12 bits, then a clean 0xA5 frame.
    spi_ss = 1'b0;
    for (int i = 0; i < 12; i++) send_bit(1'($urandom_range(0, 1)));
    rst = 1'b0;
    repeat (3) @(posedge clk8M);
    #1;
    check("midrst_valid", {31'd0, rx.out_valid}, 0);
    check("midrst_ovf", {24'd0, ovf_cnt}, 0);
    rst = 1'b1;
    #THALF;
    spi_ss = 1'b1;
    #(4 * THALF);
    check("midrst_empty_after", {24'd0, empty_cnt}, 0);
    check("midrst_valid_after", {31'd0, rx.out_valid}, 0);
    q = '{8'hA5};
    model_frame(q, 0, 1000);
    send_frame(q, 0, 1'b0);
    drain("drain_a5");

    // Three-byte frame with latency checks.
    q = '{8'h8D, 8'h4C, 8'hA1};
    model_frame(q, 0, 1000);
    send_frame(q, 0, 1'b1);
    drain("drain_3byte");

    // Truncated frame: one byte then five bits.
    q = '{8'h12};
    model_frame(q, 5, 1000);
    send_frame(q, 5, 1'b0);
    drain("drain_trunc");

    // Empty frames: ss low with no sck, then three bits only.
    q = {};
    model_frame(q, 0, 1000);
    spi_ss = 1'b0;
    #10us;
    spi_ss = 1'b1;
    #(2 * THALF);
    model_frame(q, 3, 1000);
    send_frame(q, 3, 1'b0);
    check("empty_cnt", {24'd0, empty_cnt}, empty_exp);
    drain("drain_empty");

    // Overflow: 20 bytes into a stalled 16-entry FIFO.
    ready_mode = 1;
    q = {};
    for (int i = 0; i < 20; i++) q.push_back(8'($urandom));
    model_frame(q, 0, DEPTH);
    send_frame(q, 0, 1'b0);
    check("ovf_cnt", {24'd0, ovf_cnt}, ovf_exp);
    check("ovf_valid", {31'd0, rx.out_valid}, 1);
    ready_mode = 0;
    drain("drain_ovf");
    q = '{8'h5A};
    model_frame(q, 0, 1000);
    send_frame(q, 0, 1'b0);
    drain("drain_after_ovf");

    // Fresh counters, then backpressure 1,0,0,1 over a 14-byte frame.
    rst = 1'b0;
    repeat (2) @(posedge clk8M);
    rst = 1'b1;
    ovf_exp = 0;
    empty_exp = 0;
    repeat (4) @(posedge clk8M);
    ready_mode = 2;
    q = {};
    for (int i = 0; i < ADSB_LONG_BYTES; i++) q.push_back(8'($urandom));
    model_frame(q, 0, 1000);
    send_frame(q, 0, 1'b0);
    drain("drain_bp");
    check("bp_ovf", {24'd0, ovf_cnt}, 0);

    // Random frames under random backpressure.
    ready_mode = 3;
    for (int f = 0; f < 12; f++) begin
      int n = $urandom_range(1, ADSB_LONG_BYTES);
      int p = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(1, 7);
      q = {};
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      model_frame(q, p, 1000);
      send_frame(q, p, 1'b0);
    end
    drain("drain_random");
    check("final_ovf", {24'd0, ovf_cnt}, ovf_exp);
    check("final_empty", {24'd0, empty_cnt}, empty_exp);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
